nes_controller_reader: RTL and testbench

//  Console-side initiator for the NES/SNES serial pad protocol. Generates latch and serial-clock

---
 rtl/nes_pkg.sv | 35 +++
 rtl/nes_phase_timer.sv | 28 ++
 rtl/nes_controller_reader.sv | 155 +++++++++++++++
 tb/tb_nes_controller_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the NES/SNES pad reader: FSM states, button
// positions within the serial frame and default protocol timing.
package nes_pkg;

    // Frame sequencing states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SETTLE = 3'd2,
        CLK_LO = 3'd3,
        CLK_HI = 3'd4,
        DONE   = 3'd5
    } nes_state_e;

    // Bit positions of the standard NES buttons in the button word.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    // Default timing: an 8-bit NES frame with a 4-cycle serial half period.
    localparam int DEF_NUM_BITS     = 8;
    localparam int DEF_HALF_CYCLES  = 4;
    localparam int DEF_LATCH_CYCLES = 8;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_phase_timer.sv
// Loadable down-counter that times every phase of a frame. The FSM loads
// (duration - 1) on each state entry and moves on when the count hits zero.
module nes_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/nes_controller_reader.sv
// Console-side NES/SNES pad reader: drives latch and serial clock, samples
// the pad's active-low data through a synchronizer and publishes a
// registered, active-high button word with a one-cycle valid pulse.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int NUM_BITS     = DEF_NUM_BITS,
    parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                data_in,
    output logic                latch_out,
    output logic                clk_out,
    output logic [NUM_BITS-1:0] buttons,
    output logic                valid,
    output logic                busy
);

    localparam int PHASE_W = $clog2(maxInt(HALF_CYCLES, LATCH_CYCLES) + 1);
    localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [PHASE_W-1:0] HALF_LOAD  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] LATCH_LOAD = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_BITS - 1);

    nes_state_e          state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [IDX_W-1:0]    bitIdx_q, bitIdx_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [NUM_BITS-1:0] buttons_q, buttons_d;
    logic                valid_q, valid_d;
    logic                latch_q, latch_d;
    logic                clkOut_q, clkOut_d;
    logic                timerLoad;
    logic [PHASE_W-1:0]  timerLoadVal;
    logic                timerTc;

    nes_phase_timer #(
        .WIDTH(PHASE_W)
    ) u_phase_timer (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (timerLoad),
        .load_val_i (timerLoadVal),
        .tc_o       (timerTc)
    );

    // Two-flop synchronizer for the asynchronous pad data; idles high (released).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= data_in;
            sync2_q <= sync1_q;
        end
    end

    // Frame sequencing: each phase reloads the timer on entry and advances on terminal count.
    always_comb begin
        state_d      = state_q;
        bitIdx_d     = bitIdx_q;
        shreg_d      = shreg_q;
        buttons_d    = buttons_q;
        valid_d      = 1'b0;
        timerLoad    = 1'b0;
        timerLoadVal = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LATCH;
                    shreg_d      = '0;
                    timerLoad    = 1'b1;
                    timerLoadVal = LATCH_LOAD;
                end
            end
            LATCH: begin
                if (timerTc) begin
                    state_d      = SETTLE;
                    timerLoad    = 1'b1;
                    timerLoadVal = HALF_LOAD;
                end
            end
            SETTLE: begin
                if (timerTc) begin
                    state_d      = CLK_LO;
                    bitIdx_d     = '0;
                    timerLoad    = 1'b1;
                    timerLoadVal = HALF_LOAD;
                end
            end
            CLK_LO: begin
                if (timerTc) begin
                    shreg_d[bitIdx_q] = ~sync2_q;
                    state_d           = CLK_HI;
                    timerLoad         = 1'b1;
                    timerLoadVal      = HALF_LOAD;
                end
            end
            CLK_HI: begin
                if (timerTc) begin
                    if (bitIdx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        bitIdx_d     = bitIdx_q + IDX_W'(1);
                        state_d      = CLK_LO;
                        timerLoad    = 1'b1;
                        timerLoadVal = HALF_LOAD;
                    end
                end
            end
            DONE: begin
                buttons_d = shreg_q;
                valid_d   = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        latch_d  = (state_d == LATCH);
        clkOut_d = (state_d != CLK_LO);
    end

    // State, frame data and pad-pin registers; pins come straight from flops so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bitIdx_q  <= '0;
            shreg_q   <= '0;
            buttons_q <= '0;
            valid_q   <= 1'b0;
            latch_q   <= 1'b0;
            clkOut_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            bitIdx_q  <= bitIdx_d;
            shreg_q   <= shreg_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            latch_q   <= latch_d;
            clkOut_q  <= clkOut_d;
        end
    end

    assign latch_out = latch_q;
    assign clk_out   = clkOut_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nes_controller_reader.sv
// Self-checking bench for nes_controller_reader with a behavioural pad model.
module tb_nes_controller_reader;

    localparam int HALF    = 4;
    localparam int FRAME   = 77;
    localparam int BOUND   = 200;

    logic       clk;
    logic       reset;
    logic       start;
    logic       data_in;
    logic       latch_out;
    logic       clk_out;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    logic [7:0] padPattern;
    logic       padAbsent;
    logic [7:0] padShift;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] pattern;
        logic       absent;
        logic [7:0] expButtons;
    } vec_t;

    vec_t vecs[5];

    nes_controller_reader #(
        .NUM_BITS     (8),
        .HALF_CYCLES  (4),
        .LATCH_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .latch_out (latch_out),
        .clk_out   (clk_out),
        .buttons   (buttons),
        .valid     (valid),
        .busy      (busy)
    );

    // 10-unit system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pad model: 4021-style shifter holding active-low buttons, loaded while
    // latched, shifting toward data on each serial-clock rise, filling with 1s.
    initial padShift = 8'hFF;
    always @(posedge latch_out or posedge clk_out) begin
        if (latch_out) padShift = ~padPattern;
        else           padShift = {1'b1, padShift[7:1]};
    end
    assign data_in = padAbsent ? 1'b1 : padShift[0];

    // One comparison: bump the counters and report any difference.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Run one frame from a one-cycle start pulse, measuring latency to valid,
    // serial clock edges, latch width and any malformed pulse; optionally
    // re-pulses start mid-frame at cycle repulseAt.
    task automatic applyStimulus(input logic [7:0] pattern, input logic absent, input int repulseAt,
                                 output int latency, output int falls, output int rises,
                                 output int latchHigh, output int badPulse);
        int   cycles;
        int   runLen;
        logic prevClk;
        padPattern = pattern;
        padAbsent  = absent;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cycles    = 0;
        falls     = 0;
        rises     = 0;
        latchHigh = 0;
        badPulse  = 0;
        runLen    = 0;
        prevClk   = clk_out;
        while (!valid && cycles < BOUND) begin
            if (cycles == repulseAt)     start = 1'b1;
            if (cycles == repulseAt + 1) start = 1'b0;
            if (latch_out) latchHigh++;
            if (latch_out && !clk_out) badPulse++;
            if (clk_out != prevClk) begin
                if (!prevClk && runLen != HALF) badPulse++;
                if (prevClk && falls > 0 && runLen != HALF) badPulse++;
                if (!clk_out) falls++;
                else          rises++;
                runLen = 1;
            end else begin
                runLen++;
            end
            prevClk = clk_out;
            @(negedge clk);
            cycles++;
        end
        start   = 1'b0;
        latency = cycles;
    endtask

    // Count valid pulses over a window and confirm the reader stays idle.
    task automatic watchIdle(input int ncycles, output int valids, output int busyCycles);
        valids     = 0;
        busyCycles = 0;
        for (int i = 0; i < ncycles; i++) begin
            @(negedge clk);
            if (valid) valids++;
            if (busy)  busyCycles++;
        end
    endtask

    // Main sequence: reset check, table of frames, then multi-cycle corner cases.
    initial begin
        int lat, nf, nr, nl, nb, nv, nbusy;
        int frameIdx, lastValid, cyc;
        logic [7:0] expPat;

        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        padPattern = 8'h00;
        padAbsent  = 1'b0;

        vecs[0] = '{pattern: 8'h81, absent: 1'b0, expButtons: 8'h81};
        vecs[1] = '{pattern: 8'h5A, absent: 1'b1, expButtons: 8'h00};
        vecs[2] = '{pattern: 8'hFF, absent: 1'b0, expButtons: 8'hFF};
        vecs[3] = '{pattern: 8'h3C, absent: 1'b0, expButtons: 8'h3C};
        vecs[4] = '{pattern: 8'h00, absent: 1'b0, expButtons: 8'h00};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: every output at its rest value for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_outputs_c%0d", i),
                        int'({latch_out, clk_out, buttons, valid, busy}),
                        int'({1'b0, 1'b1, 8'h00, 1'b0, 1'b0}));
        end

        // Table-driven frames: timing, edge counts and decoded button word.
        foreach (vecs[v]) begin
            applyStimulus(vecs[v].pattern, vecs[v].absent, -10, lat, nf, nr, nl, nb);
            checkOutput($sformatf("v%0d_latency", v), lat, FRAME);
            checkOutput($sformatf("v%0d_buttons", v), int'(buttons), int'(vecs[v].expButtons));
            checkOutput($sformatf("v%0d_falls", v), nf, 8);
            checkOutput($sformatf("v%0d_rises", v), nr, 8);
            checkOutput($sformatf("v%0d_latch_cycles", v), nl, 8);
            checkOutput($sformatf("v%0d_bad_pulses", v), nb, 0);
            checkOutput($sformatf("v%0d_busy_at_valid", v), int'(busy), 0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_valid_one_cycle", v), int'(valid), 0);
            checkOutput($sformatf("v%0d_buttons_hold", v), int'(buttons), int'(vecs[v].expButtons));
        end
        padAbsent = 1'b0;

        // Start re-pulsed mid-frame must be dropped, not queued.
        applyStimulus(8'h24, 1'b0, 30, lat, nf, nr, nl, nb);
        checkOutput("repulse_latency", lat, FRAME);
        checkOutput("repulse_falls", nf, 8);
        checkOutput("repulse_buttons", int'(buttons), 8'h24);
        watchIdle(100, nv, nbusy);
        checkOutput("repulse_extra_valids", nv, 0);
        checkOutput("repulse_busy_after", nbusy, 0);

        // Reset in the middle of a frame that follows a completed 8'h81 frame.
        applyStimulus(8'h81, 1'b0, -10, lat, nf, nr, nl, nb);
        checkOutput("prereset_buttons", int'(buttons), 8'h81);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        checkOutput("midframe_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_outputs", int'({latch_out, clk_out, buttons, valid, busy}),
                    int'({1'b0, 1'b1, 8'h00, 1'b0, 1'b0}));
        watchIdle(100, nv, nbusy);
        checkOutput("reset_no_valid", nv, 0);
        checkOutput("reset_stays_idle", nbusy, 0);
        checkOutput("reset_buttons_cleared", int'(buttons), 0);
        applyStimulus(8'h81, 1'b0, -10, lat, nf, nr, nl, nb);
        checkOutput("postreset_latency", lat, FRAME);
        checkOutput("postreset_buttons", int'(buttons), 8'h81);

        // Start held high: back-to-back frames, pad pattern alternating 55/AA.
        @(negedge clk);
        padPattern = 8'h55;
        expPat     = 8'h55;
        start      = 1'b1;
        frameIdx   = 0;
        lastValid  = 0;
        cyc        = 0;
        while (frameIdx < 4 && cyc < 4 * BOUND) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                checkOutput($sformatf("held_f%0d_buttons", frameIdx), int'(buttons), int'(expPat));
                if (frameIdx > 0)
                    checkOutput($sformatf("held_f%0d_period", frameIdx), cyc - lastValid, FRAME + 1);
                lastValid  = cyc;
                expPat     = ~expPat;
                padPattern = expPat;
                frameIdx++;
            end
        end
        checkOutput("held_frames_seen", frameIdx, 4);
        start = 1'b0;
        cyc   = 0;
        while (busy && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("held_busy_released", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
